multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Control unit for the multicycle RV32 datapath. Drives the ALU's 3-bit ALUControl and every datapath mux select and write enable.
- Moore main FSM, plus a combinational ALU decoder and an immediate-source decoder.
- Supported subset: lw, sw, R-type, I-type ALU, beq, jal.
- Sits between the instruction register (op/funct fields) and the ALU, register file, memory and PC.

Parameters:
ILLEGAL_TRAP, 0, 0: unsupported opcode returns to FETCH (NOP); 1: unsupported opcode enters HALT until reset.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
op  in  7  opcode from instruction register
funct3  in  3  instr[14:12]
funct7b5  in  1  instr[30]
Zero  in  1  ALU zero flag
PCWrite  out  1  PC load enable = (Branch & Zero) | PCUpdate
AdrSrc  out  1  memory address select: 0 PC, 1 Result
MemWrite  out  1  data memory write enable
IRWrite  out  1  instruction register load
ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
ALUSrcA  out  2  00 PC, 01 OldPC, 10 RD1
ALUSrcB  out  2  00 RD2, 01 ImmExt, 10 constant 4
RegWrite  out  1  register file write enable
ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
ALUControl  out  3  000 add, 001 sub, 111 and, 011 or, 101 slt
illegal  out  1  unsupported opcode seen in DECODE
state_dbg  out  4  current state code

Behaviour:
- Reset is synchronous: on a clk edge with reset=1, state <= FETCH (0).
- While reset=1, PCWrite, IRWrite, MemWrite, RegWrite and illegal are forced 0. The other outputs follow state.
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, ALUWB 7, EXECUTEI 8, JAL 9, BEQ 10, HALT 11. Codes 12-15 go to FETCH on the next edge.
- Outputs are a function of state only, except PCWrite (uses Zero) and ALUControl/ImmSrc (use op/funct). Any output not listed for a state is 0.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1. Next: DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Next by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - any other op -> illegal=1 this cycle; next FETCH if ILLEGAL_TRAP=0, HALT if ILLEGAL_TRAP=1.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: ResultSrc=00, AdrSrc=1. Next: MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next: FETCH.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1. Next: FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next: FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next: FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next: ALUWB.
- HALT: all enables 0, illegal held at 1. Only reset leaves HALT.
- Instruction cycle counts, FETCH to FETCH: lw 5, sw 4, R 4, I 4, jal 4, beq 3.
- ALU decoder (combinational):
  - ALUOp 00 -> 000 (add); ALUOp 01 -> 001 (sub); ALUOp 11 -> 000.
  - ALUOp 10, by funct3: 000 -> 001 if (op[5] & funct7b5) else 000; 010 -> 101; 110 -> 011; 111 -> 111; any other funct3 -> 000.
  - So addi with instr[30]=1 still adds.
- ImmSrc by op: 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, all others -> 00.
- op/funct are the IR outputs and are stable from DECODE to the end of the instruction. The block does not register them.
- Reset asserted mid-instruction: the next state is FETCH regardless of the current state. No MemWrite or RegWrite pulse occurs during the reset cycle.

Test Plan:
- Reset 2 cycles, then lw (op=0000011) -> state_dbg 0,1,2,3,4,0. IRWrite=1 only in state 0. RegWrite=1 and ResultSrc=01 only in state 4. ALUControl=000 in state 2.
- sw (op=0100011) -> states 0,1,2,5,0. MemWrite=1 and AdrSrc=1 in state 5 only. ImmSrc=01.
- R-type funct3=000, funct7b5=1 -> ALUControl=001 in state 6. Repeat for funct3=010/110/111 -> 101/011/111. addi with instr[30]=1 -> 000 in state 8.
- beq: with Zero=1 in state 10 -> PCWrite=1; with Zero=0 -> PCWrite=0. Next state 0. ImmSrc=10.
- jal -> states 0,1,9,7,0. PCWrite=1 in state 9, RegWrite=1 in state 7. Illegal op=0000000: with ILLEGAL_TRAP=0 -> illegal pulses 1 cycle in state 1, then state 0. With ILLEGAL_TRAP=1 -> state 11 held with illegal=1 until reset.
- Assert reset while in MEMWRITE (5) -> MemWrite=0 that cycle, state_dbg=0 next cycle.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control-unit bus: instruction fields and ALU flag in, datapath selects and enables out.
// The controller uses the master view; the datapath side (or a testbench) uses the slave view.
interface multicycle_control_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       RegWrite;
  logic [1:0] ImmSrc;
  logic [2:0] ALUControl;
  logic       illegal;
  logic [3:0] state_dbg;

  modport master (
    input  op, funct3, funct7b5, Zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           RegWrite, ImmSrc, ALUControl, illegal, state_dbg
  );

  modport slave (
    output op, funct3, funct7b5, Zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           RegWrite, ImmSrc, ALUControl, illegal, state_dbg
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle RV32 control unit: Moore main FSM with registered per-state controls,
// plus combinational ALU and immediate-source decoders.
module multicycle_control #(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  multicycle_control_if.master io_bus
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StAluWb    = 4'd7,
    StExecI    = 4'd8,
    StJal      = 4'd9,
    StBeq      = 4'd10,
    StHalt     = 4'd11
  } state_e;

  typedef struct packed {
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic [1:0] alu_op;
    logic       branch;
    logic       pc_update;
    logic       halt;
  } ctl_t;

  localparam logic [6:0] OpLw  = 7'b0000011;
  localparam logic [6:0] OpSw  = 7'b0100011;
  localparam logic [6:0] OpR   = 7'b0110011;
  localparam logic [6:0] OpI   = 7'b0010011;
  localparam logic [6:0] OpBeq = 7'b1100011;
  localparam logic [6:0] OpJal = 7'b1101111;

  // Controls are registered alongside the state, so they are decoded from the next state.
  function automatic ctl_t ctl_of(state_e s);
    ctl_t c;
    c = '0;
    case (s)
      StFetch: begin
        c.ir_write   = 1'b1;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
        c.pc_update  = 1'b1;
      end
      StDecode: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
      end
      StMemAdr: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
      end
      StMemRead:  c.adr_src = 1'b1;
      StMemWb: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
      end
      StMemWrite: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      StExecR: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b10;
      end
      StAluWb:    c.reg_write = 1'b1;
      StExecI: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b10;
      end
      StJal: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
        c.pc_update = 1'b1;
      end
      StBeq: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b01;
        c.branch    = 1'b1;
      end
      StHalt:     c.halt = 1'b1;
      default:    c = '0;
    endcase
    return c;
  endfunction

  state_e r_state;
  ctl_t   r_ctl;
  state_e w_next;
  logic   w_op_known;

  always_comb begin
    w_op_known = 1'b0;
    case (io_bus.op)
      OpLw, OpSw, OpR, OpI, OpBeq, OpJal: w_op_known = 1'b1;
      default:                            w_op_known = 1'b0;
    endcase
  end

  always_comb begin
    w_next = StFetch;
    case (r_state)
      StFetch:  w_next = StDecode;
      StDecode: begin
        case (io_bus.op)
          OpLw, OpSw: w_next = StMemAdr;
          OpR:        w_next = StExecR;
          OpI:        w_next = StExecI;
          OpBeq:      w_next = StBeq;
          OpJal:      w_next = StJal;
          default:    w_next = ILLEGAL_TRAP ? StHalt : StFetch;
        endcase
      end
      StMemAdr:   w_next = (io_bus.op == OpLw) ? StMemRead : StMemWrite;
      StMemRead:  w_next = StMemWb;
      StExecR:    w_next = StAluWb;
      StExecI:    w_next = StAluWb;
      StJal:      w_next = StAluWb;
      StHalt:     w_next = StHalt;
      default:    w_next = StFetch;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StFetch;
      r_ctl   <= ctl_of(StFetch);
    end else begin
      r_state <= w_next;
      r_ctl   <= ctl_of(w_next);
    end
  end

  logic [2:0] w_alu_control;
  logic [1:0] w_imm_src;

  always_comb begin
    w_alu_control = 3'b000;
    case (r_ctl.alu_op)
      2'b01: w_alu_control = 3'b001;
      2'b10: begin
        case (io_bus.funct3)
          3'b000:  w_alu_control = (io_bus.op[5] & io_bus.funct7b5) ? 3'b001 : 3'b000;
          3'b010:  w_alu_control = 3'b101;
          3'b110:  w_alu_control = 3'b011;
          3'b111:  w_alu_control = 3'b111;
          default: w_alu_control = 3'b000;
        endcase
      end
      default: w_alu_control = 3'b000;
    endcase
  end

  always_comb begin
    w_imm_src = 2'b00;
    case (io_bus.op)
      OpSw:    w_imm_src = 2'b01;
      OpBeq:   w_imm_src = 2'b10;
      OpJal:   w_imm_src = 2'b11;
      default: w_imm_src = 2'b00;
    endcase
  end

  // Enables are masked during reset so a mid-instruction reset cannot commit a write.
  assign io_bus.PCWrite    = ~i_reset & ((r_ctl.branch & io_bus.Zero) | r_ctl.pc_update);
  assign io_bus.MemWrite   = ~i_reset & r_ctl.mem_write;
  assign io_bus.IRWrite    = ~i_reset & r_ctl.ir_write;
  assign io_bus.RegWrite   = ~i_reset & r_ctl.reg_write;
  assign io_bus.illegal    = ~i_reset & (r_ctl.halt | ((r_state == StDecode) & ~w_op_known));
  assign io_bus.AdrSrc     = r_ctl.adr_src;
  assign io_bus.ResultSrc  = r_ctl.result_src;
  assign io_bus.ALUSrcA    = r_ctl.alu_src_a;
  assign io_bus.ALUSrcB    = r_ctl.alu_src_b;
  assign io_bus.ALUControl = w_alu_control;
  assign io_bus.ImmSrc     = w_imm_src;
  assign io_bus.state_dbg  = r_state;

endmodule
